// File: rtl/rally_court_engine.sv
// Two-player LED tennis/squash rally engine: tick-driven one-hot ball, timed hit
// windows at the court ends, scoring with server alternation, and a floored speed-up.
module rally_court_engine #(
  parameter int unsigned         N_LEDS     = 16,
  parameter int unsigned         POS_W      = 4,
  parameter int unsigned         SCORE_W    = 3,
  parameter int unsigned         WIN_SCORE  = 3,
  parameter int unsigned         PERIOD_W   = 28,
  parameter logic [PERIOD_W-1:0] SPEED_INIT = 28'd32_800_000,
  parameter logic [PERIOD_W-1:0] SPEED_MIN  = 28'd2_000_000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [1:0]          hits,
  input  logic                squash,
  output logic [N_LEDS-1:0]   court,
  output logic [SCORE_W-1:0]  score0,
  output logic [SCORE_W-1:0]  score1,
  output logic [4:0]          events,
  output logic [PERIOD_W-1:0] period,
  output logic                game_over
);

  typedef enum logic [1:0] {SERVE, FLY, WINDOW, WIN} state_t;

  localparam logic [POS_W-1:0]   TOP   = POS_W'(N_LEDS - 1);
  localparam logic [SCORE_W-1:0] WIN_S = SCORE_W'(WIN_SCORE);
  localparam logic [N_LEDS-1:0]  LED0  = {{(N_LEDS-1){1'b0}}, 1'b1};

  state_t               state, state_n;
  logic [POS_W-1:0]     pos, pos_n, step_pos;
  logic                 dir, dir_n;        // 1 = toward N_LEDS-1
  logic                 server, server_n, srv;
  logic                 mode, mode_n, mode_eff;
  logic [N_LEDS-1:0]    court_n;
  logic [SCORE_W-1:0]   score0_n, score1_n;
  logic [4:0]           events_n;
  logic [PERIOD_W-1:0]  period_n, cnt, cnt_n, half;
  logic                 game_over_n;
  logic [1:0]           hits_q, press;
  logic                 tick, recv, award, scorer;

  function automatic logic [SCORE_W-1:0] bump(input logic [SCORE_W-1:0] s);
    return (s >= WIN_S) ? WIN_S : s + SCORE_W'(1);
  endfunction

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= SERVE;
      pos       <= '0;
      dir       <= 1'b1;
      server    <= 1'b0;
      mode      <= 1'b0;
      court     <= LED0;
      score0    <= '0;
      score1    <= '0;
      events    <= '0;
      period    <= SPEED_INIT;
      cnt       <= '0;
      hits_q    <= '0;
      game_over <= 1'b0;
    end else begin
      state     <= state_n;
      pos       <= pos_n;
      dir       <= dir_n;
      server    <= server_n;
      mode      <= mode_n;
      court     <= court_n;
      score0    <= score0_n;
      score1    <= score1_n;
      events    <= events_n;
      period    <= period_n;
      cnt       <= cnt_n;
      hits_q    <= hits;
      game_over <= game_over_n;
    end
  end

  always_comb begin
    press       = hits & ~hits_q;
    tick        = (cnt == period - PERIOD_W'(1));
    mode_eff    = (state == SERVE || state == WIN) ? squash : mode;
    // Squash has a single live player; otherwise the receiver is the end the ball heads to.
    recv        = mode ? 1'b0 : dir;
    step_pos    = dir ? pos + POS_W'(1) : pos - POS_W'(1);
    half        = period >> 1;
    srv         = mode_eff ? 1'b0 : server;
    state_n     = state;
    pos_n       = pos;
    dir_n       = dir;
    server_n    = server;
    mode_n      = mode_eff;
    score0_n    = score0;
    score1_n    = score1;
    events_n    = '0;
    period_n    = period;
    cnt_n       = tick ? '0 : cnt + PERIOD_W'(1);
    game_over_n = game_over;
    award       = 1'b0;
    scorer      = 1'b0;

    case (state)
      SERVE: begin
        server_n = srv;
        pos_n    = srv ? TOP : '0;
        dir_n    = ~srv;
        if (press[srv]) begin
          state_n  = FLY;
          period_n = SPEED_INIT;
          cnt_n    = '0;
        end
      end
      FLY: begin
        if (press[recv]) begin
          events_n[recv ? 3 : 2] = 1'b1;
          award  = 1'b1;
          scorer = ~recv;
        end else if (tick) begin
          pos_n = step_pos;
          if (mode && dir && step_pos == TOP) begin
            dir_n = 1'b0;
          end else if (dir ? (step_pos == TOP) : (step_pos == '0)) begin
            state_n = WINDOW;
            cnt_n   = '0;
          end
        end
      end
      WINDOW: begin
        if (press[recv]) begin
          dir_n       = ~dir;
          events_n[4] = 1'b1;
          period_n    = (half < SPEED_MIN) ? SPEED_MIN : half;
          cnt_n       = '0;
          state_n     = FLY;
          if (mode) begin
            score0_n = bump(score0);
            if (score0_n == WIN_S) begin
              state_n     = WIN;
              game_over_n = 1'b1;
            end
          end
        end else if (tick) begin
          events_n[recv] = 1'b1;
          award  = 1'b1;
          scorer = ~recv;
        end
      end
      WIN: begin
        if (|press) begin
          server_n    = mode_eff ? 1'b0 : (score0 == WIN_S);
          score0_n    = '0;
          score1_n    = '0;
          game_over_n = 1'b0;
          state_n     = SERVE;
          period_n    = SPEED_INIT;
          pos_n       = server_n ? TOP : '0;
          dir_n       = ~server_n;
          cnt_n       = '0;
        end
      end
      default: state_n = SERVE;
    endcase

    if (award) begin
      if (scorer) score1_n = bump(score1);
      else        score0_n = bump(score0);
      cnt_n = '0;
      if ((scorer ? score1_n : score0_n) == WIN_S) begin
        state_n     = WIN;
        game_over_n = 1'b1;
      end else begin
        state_n  = SERVE;
        period_n = SPEED_INIT;
        server_n = mode ? 1'b0 : ~server;
        pos_n    = server_n ? TOP : '0;
        dir_n    = ~server_n;
      end
    end

    if (state_n == WIN) court_n = (score0_n == WIN_S) ? '0 : '1;
    else                court_n = LED0 << pos_n;
  end

endmodule

// File: tb/tb_rally_court_engine.sv
// Bench for rally_court_engine: directed rally scenarios followed by random play,
// every clock compared against a rule-level reference model.
module tb_rally_court_engine;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] hits = 2'b00;
  logic       squash = 1'b0;
  logic [7:0] court;
  logic [2:0] score0, score1;
  logic [4:0] events;
  logic [7:0] period;
  logic       game_over;

  int compared = 0;
  int mismatched = 0;
  logic cur_sq = 1'b0;

  rally_court_engine #(
    .N_LEDS(8), .POS_W(3), .SCORE_W(3), .WIN_SCORE(3),
    .PERIOD_W(8), .SPEED_INIT(8'd8), .SPEED_MIN(8'd2)
  ) dut (
    .clock(clock), .reset(reset), .hits(hits), .squash(squash),
    .court(court), .score0(score0), .score1(score1), .events(events),
    .period(period), .game_over(game_over)
  );

  always #5 clock = ~clock;

  // Reference model: ball as integer position with +1/-1 direction, flags for phase.
  int   m_pos, m_dir, m_server, m_s0, m_s1, m_per, m_age, m_ev;
  bit   m_sq, m_play, m_window, m_over;
  logic [1:0] m_hq;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_point(input int w);
    if (w == 1) m_s1 = (m_s1 < 3) ? m_s1 + 1 : 3;
    else        m_s0 = (m_s0 < 3) ? m_s0 + 1 : 3;
    m_play = 0; m_window = 0; m_age = 0;
    if ((w == 1 ? m_s1 : m_s0) == 3) m_over = 1;
    else begin
      m_per = 8;
      m_server = m_sq ? 0 : 1 - m_server;
      m_pos = m_server ? 7 : 0;
      m_dir = m_server ? -1 : 1;
    end
  endtask

  task automatic model_step(input logic rst, input logic [1:0] h, input logic sq);
    logic [1:0] p;
    bit tick;
    int recv;
    m_ev = -1;
    if (!rst) begin
      m_pos = 0; m_dir = 1; m_server = 0; m_sq = 0; m_s0 = 0; m_s1 = 0;
      m_per = 8; m_age = 0; m_play = 0; m_window = 0; m_over = 0; m_hq = 2'b00;
      return;
    end
    p = h & ~m_hq;
    m_hq = h;
    if (m_over || !m_play) m_sq = sq;
    tick = (m_age + 1 == m_per);
    m_age = tick ? 0 : m_age + 1;
    recv = m_sq ? 0 : (m_dir > 0 ? 1 : 0);
    if (m_over) begin
      if (p != 2'b00) begin
        m_server = m_sq ? 0 : (m_s0 == 3 ? 1 : 0);
        m_s0 = 0; m_s1 = 0; m_over = 0; m_per = 8; m_age = 0;
        m_pos = m_server ? 7 : 0;
        m_dir = m_server ? -1 : 1;
      end
    end else if (!m_play) begin
      if (m_sq) m_server = 0;
      m_pos = m_server ? 7 : 0;
      m_dir = m_server ? -1 : 1;
      if (p[m_server]) begin m_play = 1; m_window = 0; m_per = 8; m_age = 0; end
    end else if (!m_window) begin
      if (p[recv]) begin
        m_ev = 2 + recv;
        model_point(1 - recv);
      end else if (tick) begin
        m_pos += m_dir;
        if (m_sq && m_dir > 0 && m_pos == 7) m_dir = -1;
        else if ((m_dir > 0 && m_pos == 7) || (m_dir < 0 && m_pos == 0)) begin
          m_window = 1; m_age = 0;
        end
      end
    end else begin
      if (p[recv]) begin
        m_ev = 4; m_dir = -m_dir; m_age = 0; m_window = 0;
        m_per = (m_per / 2 < 2) ? 2 : m_per / 2;
        if (m_sq) begin
          m_s0 = (m_s0 < 3) ? m_s0 + 1 : 3;
          if (m_s0 == 3) begin m_over = 1; m_play = 0; end
        end
      end else if (tick) begin
        m_ev = recv;
        model_point(1 - recv);
      end
    end
  endtask

  task automatic check_all();
    logic [7:0] ec;
    ec = m_over ? ((m_s0 == 3) ? 8'h00 : 8'hFF) : 8'(1 << m_pos);
    chk("court", court, ec);
    chk("score0", score0, m_s0);
    chk("score1", score1, m_s1);
    chk("events", events, (m_ev < 0) ? 0 : (1 << m_ev));
    chk("period", period, m_per);
    chk("game_over", game_over, m_over);
  endtask

  task automatic step(input logic [1:0] h, input logic sq, input logic rst);
    hits = h; squash = sq; reset = rst;
    @(posedge clock);
    model_step(rst, h, sq);
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(2'b00, cur_sq, 1'b1);
  endtask

  task automatic press(input logic [1:0] b);
    step(b, cur_sq, 1'b1);
  endtask

  // what: 0 = hit window open, 1 = rally over, 2 = ball at LED 3 moving up
  task automatic wait_for(input int what, input string tag);
    bit ok = 0;
    for (int i = 0; i < 400 && !ok; i++) begin
      case (what)
        0: ok = m_window;
        1: ok = !m_play || m_over;
        default: ok = m_play && !m_window && m_pos == 3 && m_dir > 0;
      endcase
      if (!ok) idle(1);
    end
    compared++;
    assert (ok) else begin
      mismatched++;
      $error("FAIL %s: observed timeout expected condition within 400 clocks", tag);
    end
  endtask

  initial begin
    step(2'b00, 1'b0, 1'b0);
    step(2'b00, 1'b0, 1'b0);
    chk("reset_court", court, 8'h01);
    chk("reset_period", period, 8'd8);
    chk("reset_game_over", game_over, 1'b0);

    press(2'b01);
    idle(56);
    chk("serve_reaches_top", court, 8'h80);
    press(2'b10);
    chk("return_pulse", events, 5'h10);
    chk("speedup_8_to_4", period, 8'd4);
    wait_for(0, "window_low");
    press(2'b01);
    chk("speedup_4_to_2", period, 8'd2);
    wait_for(0, "window_high");
    press(2'b10);
    chk("speed_floor", period, 8'd2);
    wait_for(0, "window_low2");
    press(2'b01);
    wait_for(1, "miss_p1");
    chk("miss_score0", score0, 3'd1);
    chk("miss_court", court, 8'h80);
    press(2'b01);
    idle(9);
    chk("nonserver_ignored", court, 8'h80);

    press(2'b10);
    wait_for(1, "miss_p0");
    chk("miss_score1", score1, 3'd1);

    press(2'b01);
    wait_for(2, "ball_at_3");
    step(2'b10, cur_sq, 1'b1);
    chk("early_event", events, 5'h08);
    for (int i = 0; i < 9; i++) step(2'b10, cur_sq, 1'b1);
    chk("held_no_rescore", score0, 3'd2);
    idle(1);

    press(2'b10);
    wait_for(0, "window_p0");
    press(2'b01);
    wait_for(1, "to_win");
    chk("win_court", court, 8'h00);
    chk("win_flag", game_over, 1'b1);
    press(2'b01);
    chk("restart_score0", score0, 3'd0);
    chk("restart_loser_serves", court, 8'h80);

    cur_sq = 1'b1;
    idle(2);
    chk("squash_server0", court, 8'h01);
    press(2'b01);
    wait_for(0, "squash_window");
    press(2'b01);
    chk("squash_return_point", score0, 3'd1);
    cur_sq = 1'b0;
    idle(5);
    wait_for(0, "squash_window2");
    press(2'b01);
    chk("squash_mode_held", score0, 3'd2);
    idle(5);
    step(2'b00, cur_sq, 1'b0);
    chk("midflight_reset_court", court, 8'h01);
    chk("midflight_reset_score", score0, 3'd0);

    for (int i = 0; i < 4000; i++) begin
      logic [1:0] h;
      logic rst;
      int recv;
      rst = ($urandom_range(0, 999) != 0);
      h[0] = ($urandom_range(0, 63) == 0);
      h[1] = ($urandom_range(0, 63) == 0);
      recv = m_sq ? 0 : (m_dir > 0 ? 1 : 0);
      if (m_window && $urandom_range(0, 3) == 0) h[recv] = 1'b1;
      if ($urandom_range(0, 199) == 0) cur_sq = ~cur_sq;
      step(h, cur_sq, rst);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
